pc_fetch_ctrl: RTL and testbench

Program counter and fetch controller for the core. It owns the instruction address and sequences one program run from Start to Halt. It drives the 4-bit branch-table index to the branch-target lookup table and consumes that table's 9-bit Target in the same cycle. Next-PC selection covers sequential, taken absolute (table) branches and taken relative branches, plus run/done/fault status for the testbench harness.

---
 rtl/pc_pkg.sv | 31 +++
 rtl/pc_fetch_ctrl_if.sv | 35 +++
 rtl/sat_counter.sv | 35 +++
 rtl/pc_fetch_ctrl.sv | 87 ++++++++
 tb/tb_pc_fetch_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types, widths and next-PC arithmetic for the fetch controller.
package pc_pkg;

   localparam int unsigned PC_W  = 9;
   localparam int unsigned IDX_W = 4;
   localparam int unsigned OFF_W = 6;
   localparam int unsigned CNT_W = 16;

   // Lookup-table output reserved for "no mapping for this index".
   localparam logic [PC_W-1:0] BAD_TARGET = 9'h0FF;

   typedef enum logic [1:0] {StIdle, StRun, StDone, StFault} state_e;

   typedef enum logic [1:0] {PcHold, PcSeq, PcAbs, PcRel} pc_sel_e;

   // All arithmetic is PC_W wide, so every result wraps modulo 2^PC_W.
   function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0]  pc,
                                                input pc_sel_e          sel,
                                                input logic [PC_W-1:0]  target,
                                                input logic [OFF_W-1:0] off);
      logic [PC_W-1:0] off_ext;
      off_ext = {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
      case (sel)
         PcSeq:   next_pc = pc + PC_W'(1);
         PcAbs:   next_pc = target;
         PcRel:   next_pc = pc + off_ext;
         default: next_pc = pc;
      endcase
   endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Decode/lookup-table/status bundle between the core and the fetch controller.
interface pc_fetch_ctrl_if;
   import pc_pkg::*;

   logic              Start;
   logic [PC_W-1:0]   StartAddr;
   logic              Stall;
   logic              Halt;
   logic              BranchAbs;
   logic              BranchRel;
   logic              Taken;
   logic [IDX_W-1:0]  LutIdx;
   logic [OFF_W-1:0]  RelOff;
   logic [PC_W-1:0]   Target;
   logic              DoneAck;
   logic [IDX_W-1:0]  LutAddr;
   logic [PC_W-1:0]   PC;
   logic              Running;
   logic              Done;
   logic              Fault;
   logic [CNT_W-1:0]  CycleCnt;

   modport master (
      output Start, StartAddr, Stall, Halt, BranchAbs, BranchRel, Taken, LutIdx, RelOff,
             Target, DoneAck,
      input  LutAddr, PC, Running, Done, Fault, CycleCnt
   );

   modport slave (
      input  Start, StartAddr, Stall, Halt, BranchAbs, BranchRel, Taken, LutIdx, RelOff,
             Target, DoneAck,
      output LutAddr, PC, Running, Done, Fault, CycleCnt
   );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             en_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] count_q, count_d;

   // Clear has priority; increment stops once all bits are set.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + Width'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and run sequencer: Start -> RUN -> DONE/FAULT, with table and
// relative branches resolved in the cycle they are decoded.
module pc_fetch_ctrl
   import pc_pkg::*;
(
   input logic            Clk,
   input logic            Reset,
   pc_fetch_ctrl_if.slave fetch_if
);

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   pc_sel_e          pc_sel;
   logic             restart;
   logic             cnt_en;
   logic [CNT_W-1:0] cycle_cnt;

   // Next-state and next-PC selection.
   always_comb begin
      state_d = state_q;
      pc_sel  = PcHold;
      restart = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         StIdle: begin
            if (fetch_if.Start) restart = 1'b1;
         end
         StRun: begin
            cnt_en = 1'b1;
            if (!fetch_if.Stall) begin
               if (fetch_if.BranchAbs && fetch_if.BranchRel) begin
                  state_d = StFault;
               end else if (fetch_if.Halt) begin
                  state_d = StDone;
               end else if (fetch_if.BranchAbs && fetch_if.Taken) begin
                  if (fetch_if.Target == BAD_TARGET) state_d = StFault;
                  else                               pc_sel  = PcAbs;
               end else if (fetch_if.BranchRel && fetch_if.Taken) begin
                  pc_sel = PcRel;
               end else begin
                  pc_sel = PcSeq;
               end
            end
         end
         StDone: begin
            if (fetch_if.Start)        restart = 1'b1;
            else if (fetch_if.DoneAck) state_d = StIdle;
         end
         StFault: begin
            if (fetch_if.Start) restart = 1'b1;
         end
         default: state_d = StIdle;
      endcase
      if (restart) state_d = StRun;
      pc_d = restart ? fetch_if.StartAddr
                     : next_pc(pc_q, pc_sel, fetch_if.Target, fetch_if.RelOff);
   end

   // State and PC registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= StIdle;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   sat_counter #(
      .Width (CNT_W)
   ) u_cycle_cnt (
      .clk_i   (Clk),
      .rst_ni  (Reset),
      .clear_i (restart),
      .en_i    (cnt_en),
      .count_o (cycle_cnt)
   );

   assign fetch_if.LutAddr  = fetch_if.LutIdx;
   assign fetch_if.PC       = pc_q;
   assign fetch_if.Running  = (state_q == StRun);
   assign fetch_if.Done     = (state_q == StDone);
   assign fetch_if.Fault    = (state_q == StFault);
   assign fetch_if.CycleCnt = cycle_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scenario bench for pc_fetch_ctrl: expected {PC, Running/Done/Fault, CycleCnt}
// words are queued as stimulus is driven and popped after the following edge.
module tb_pc_fetch_ctrl;

   logic Clk = 1'b0;
   logic Reset;

   pc_fetch_ctrl_if bus ();

   pc_fetch_ctrl dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .fetch_if (bus)
   );

   always #5 Clk = ~Clk;

   int          checks   = 0;
   int          failures = 0;
   logic [27:0] sb[$];
   logic [27:0] got, want;

   function automatic logic [27:0] obs();
      return {bus.PC, bus.Running, bus.Done, bus.Fault, bus.CycleCnt};
   endfunction

   task automatic drive(input logic st, input logic [8:0] addr, input logic stall,
                        input logic halt, input logic babs, input logic brel,
                        input logic taken, input logic [8:0] tgt, input logic [5:0] off,
                        input logic ack);
      bus.Start     = st;
      bus.StartAddr = addr;
      bus.Stall     = stall;
      bus.Halt      = halt;
      bus.BranchAbs = babs;
      bus.BranchRel = brel;
      bus.Taken     = taken;
      bus.Target    = tgt;
      bus.RelOff    = off;
      bus.DoneAck   = ack;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      bus.LutIdx = '0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      got = obs();
      checks++;
      if (got !== 28'h0) begin
         failures++;
         $display("FAIL reset_init got %h want %h", got, 28'h0);
      end
      #11 Reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin drive(1, 9'h020, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back({9'h020, 3'b100, 16'd0}); end
            1: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);      sb.push_back({9'h021, 3'b100, 16'd1}); end
            2: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);      sb.push_back({9'h022, 3'b100, 16'd2}); end
            default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back({9'h023, 3'b100, 16'd3}); end
         endcase
         tick();
         want = sb.pop_front();
         got  = obs();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL reset_run[%0d] got pc=%h rdf=%b cnt=%h want pc=%h rdf=%b cnt=%h",
                     i, got[27:19], got[18:16], got[15:0], want[27:19], want[18:16], want[15:0]);
         end
      end
      // Asynchronous assertion between edges.
      #2 Reset = 1'b0;
      #1;
      got = obs();
      checks++;
      if (got !== 28'h0) begin
         failures++;
         $display("FAIL reset_async got %h want %h", got, 28'h0);
      end
      #1 Reset = 1'b1;
      drive(1, 9'h004, 0, 0, 0, 0, 0, 0, 0, 0);
      sb.push_back({9'h004, 3'b100, 16'd0});
      tick();
      want = sb.pop_front();
      got  = obs();
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL reset_restart got %h want %h", got, want);
      end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 7; i++) begin
         case (i)
            0: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back({9'h005, 3'b100, 16'd1}); end
            1: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back({9'h006, 3'b100, 16'd2}); end
            2: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back({9'h007, 3'b100, 16'd3}); end
            3: begin drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); sb.push_back({9'h007, 3'b010, 16'd4}); end
            4: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back({9'h007, 3'b010, 16'd4}); end
            5: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); sb.push_back({9'h007, 3'b000, 16'd4}); end
            default: begin
               drive(0, 0, 0, 1, 1, 0, 1, 9'h0FF, 0, 0);
               sb.push_back({9'h007, 3'b000, 16'd4});
            end
         endcase
         tick();
         want = sb.pop_front();
         got  = obs();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL seq[%0d] got pc=%h rdf=%b cnt=%h want pc=%h rdf=%b cnt=%h",
                     i, got[27:19], got[18:16], got[15:0], want[27:19], want[18:16], want[15:0]);
         end
      end
   endtask

   task automatic test_abs_branch();
      logic [3:0] idx;
      for (int k = 0; k < 2; k++) begin
         idx = (k == 0) ? 4'h3 : 4'hC;
         bus.LutIdx = idx;
         #1;
         checks++;
         if (bus.LutAddr !== idx) begin
            failures++;
            $display("FAIL lut_addr got %h want %h", bus.LutAddr, idx);
         end
      end
      for (int i = 0; i < 7; i++) begin
         case (i)
            0: begin drive(1, 9'h010, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back({9'h010, 3'b100, 16'd0}); end
            1: begin drive(0, 0, 0, 0, 1, 0, 1, 9'h09E, 0, 0); sb.push_back({9'h09E, 3'b100, 16'd1}); end
            2: begin drive(0, 0, 0, 0, 1, 0, 0, 9'h0FF, 0, 0); sb.push_back({9'h09F, 3'b100, 16'd2}); end
            3: begin drive(0, 0, 0, 0, 0, 1, 0, 0, 6'd5, 0);   sb.push_back({9'h0A0, 3'b100, 16'd3}); end
            4: begin drive(0, 0, 0, 0, 1, 0, 1, 9'h0FF, 0, 0); sb.push_back({9'h0A0, 3'b001, 16'd4}); end
            5: begin drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);      sb.push_back({9'h0A0, 3'b001, 16'd4}); end
            default: begin
               drive(1, 9'h002, 0, 0, 0, 0, 0, 0, 0, 0);
               sb.push_back({9'h002, 3'b100, 16'd0});
            end
         endcase
         tick();
         want = sb.pop_front();
         got  = obs();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL abs[%0d] got pc=%h rdf=%b cnt=%h want pc=%h rdf=%b cnt=%h",
                     i, got[27:19], got[18:16], got[15:0], want[27:19], want[18:16], want[15:0]);
         end
      end
   endtask

   task automatic test_rel_branch();
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: begin drive(0, 0, 0, 0, 0, 1, 1, 0, 6'h3D, 0); sb.push_back({9'h1FF, 3'b100, 16'd1}); end
            1: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);     sb.push_back({9'h000, 3'b100, 16'd2}); end
            2: begin drive(0, 0, 0, 0, 0, 1, 1, 0, 6'h3E, 0); sb.push_back({9'h1FE, 3'b100, 16'd3}); end
            3: begin drive(0, 0, 0, 0, 0, 1, 1, 0, 6'h05, 0); sb.push_back({9'h003, 3'b100, 16'd4}); end
            4: begin drive(0, 0, 0, 0, 0, 1, 1, 0, 6'h20, 0); sb.push_back({9'h1E3, 3'b100, 16'd5}); end
            default: begin
               drive(0, 0, 0, 0, 0, 1, 1, 0, 6'h1F, 0);
               sb.push_back({9'h002, 3'b100, 16'd6});
            end
         endcase
         tick();
         want = sb.pop_front();
         got  = obs();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL rel[%0d] got pc=%h rdf=%b cnt=%h want pc=%h rdf=%b cnt=%h",
                     i, got[27:19], got[18:16], got[15:0], want[27:19], want[18:16], want[15:0]);
         end
      end
   endtask

   task automatic test_stall_fault();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: begin drive(0, 0, 1, 1, 1, 0, 1, 9'h050, 0, 0); sb.push_back({9'h002, 3'b100, 16'd7}); end
            1: begin drive(0, 0, 1, 0, 1, 1, 1, 0, 0, 0);      sb.push_back({9'h002, 3'b100, 16'd8}); end
            default: begin
               drive(0, 0, 0, 1, 1, 1, 1, 9'h050, 0, 0);
               sb.push_back({9'h002, 3'b001, 16'd9});
            end
         endcase
         tick();
         want = sb.pop_front();
         got  = obs();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL stall[%0d] got pc=%h rdf=%b cnt=%h want pc=%h rdf=%b cnt=%h",
                     i, got[27:19], got[18:16], got[15:0], want[27:19], want[18:16], want[15:0]);
         end
      end
   endtask

   task automatic test_done_restart();
      for (int i = 0; i < 9; i++) begin
         case (i)
            0: begin drive(1, 9'h100, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back({9'h100, 3'b100, 16'd0}); end
            1: begin drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);      sb.push_back({9'h100, 3'b010, 16'd1}); end
            2: begin drive(1, 9'h1F0, 0, 0, 0, 0, 0, 0, 0, 1); sb.push_back({9'h1F0, 3'b100, 16'd0}); end
            3: begin drive(1, 9'h050, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back({9'h1F1, 3'b100, 16'd1}); end
            4: begin drive(0, 0, 0, 1, 1, 0, 1, 9'h0FF, 0, 0); sb.push_back({9'h1F1, 3'b010, 16'd2}); end
            5: begin drive(1, 9'h1FF, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back({9'h1FF, 3'b100, 16'd0}); end
            6: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);      sb.push_back({9'h000, 3'b100, 16'd1}); end
            7: begin drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);      sb.push_back({9'h000, 3'b010, 16'd2}); end
            default: begin
               drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
               sb.push_back({9'h000, 3'b000, 16'd2});
            end
         endcase
         tick();
         want = sb.pop_front();
         got  = obs();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL done[%0d] got pc=%h rdf=%b cnt=%h want pc=%h rdf=%b cnt=%h",
                     i, got[27:19], got[18:16], got[15:0], want[27:19], want[18:16], want[15:0]);
         end
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: begin drive(1, 9'h080, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back({9'h080, 3'b100, 16'd0}); end
            1: begin drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);      sb.push_back({9'h080, 3'b100, 16'hFFFE}); end
            2: begin drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);      sb.push_back({9'h080, 3'b100, 16'hFFFF}); end
            3: begin drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);      sb.push_back({9'h080, 3'b100, 16'hFFFF}); end
            default: begin
               drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
               sb.push_back({9'h080, 3'b010, 16'hFFFF});
            end
         endcase
         if (i == 1) begin
            // Burn stalled RUN cycles up to 0xFFFD before resuming the checks.
            repeat (65533) @(posedge Clk);
            #1;
         end
         tick();
         want = sb.pop_front();
         got  = obs();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL sat[%0d] got pc=%h rdf=%b cnt=%h want pc=%h rdf=%b cnt=%h",
                     i, got[27:19], got[18:16], got[15:0], want[27:19], want[18:16], want[15:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_abs_branch();
      test_rel_branch();
      test_stall_fault();
      test_done_restart();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
